gen_frame_sequencer: RTL and testbench

- Input-side scheduler for the two-stage transposed-conv generator: layer 0 → LeakyReLU → bridge FIFO → layer 1 → LeakyReLU.
- Accepts latent 8x8 frames from a host valid/ready stream and releases each frame into layer 0 only when the bridge FIFO has guaranteed room for that frame's 13x13 intermediate output.
- Counts final 23x23 outputs to report completion of a start-initiated batch.
- Provides the backpressure layer 0 lacks, so the bridge FIFO can never overflow.

---
 rtl/gen_pkg.sv | 22 ++
 rtl/gen_credit_tracker.sv | 45 ++++
 rtl/gen_frame_sequencer.sv | 108 ++++++++++
 tb/tb_gen_frame_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/gen_pkg.sv
// Shared constants and FSM state type for the generator input-side controllers.
package gen_pkg;
  localparam int GEN_IN_DIM     = 8;
  localparam int GEN_MID_DIM    = 13;
  localparam int GEN_OUT_DIM    = 23;
  localparam int GEN_IN_PIX     = GEN_IN_DIM * GEN_IN_DIM;
  localparam int GEN_MID_PIX    = GEN_MID_DIM * GEN_MID_DIM;
  localparam int GEN_OUT_PIX    = GEN_OUT_DIM * GEN_OUT_DIM;
  localparam int GEN_FIFO_DEPTH = 1024;

  localparam int OCC_W     = 11;
  localparam int FRM_W     = 8;
  localparam int OUT_CNT_W = 18;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } gen_state_e;
endpackage

// File: rtl/gen_credit_tracker.sv
// Bridge FIFO occupancy plus outstanding per-frame reservations; gates frame launch.
module gen_credit_tracker
  import gen_pkg::*;
#(
  parameter int MID_PIX    = GEN_MID_PIX,
  parameter int FIFO_DEPTH = GEN_FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic launch,
  input  logic fifo_wr,
  input  logic fifo_rd,
  output logic can_launch,
  output logic ovf,
  output logic udf
);
  localparam int W = $clog2(FIFO_DEPTH + 1);

  logic [W-1:0] occ;
  logic [W-1:0] resv;
  logic [W+1:0] need;

  // Registered counters only: a launch this cycle is not visible until next cycle.
  assign need       = {2'b00, occ} + {2'b00, resv} + (W+2)'(MID_PIX);
  assign can_launch = need <= (W+2)'(FIFO_DEPTH);
  assign ovf        = fifo_wr & ~fifo_rd & (occ == W'(FIFO_DEPTH));
  assign udf        = fifo_rd & ~fifo_wr & (occ == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= '0;
      resv <= '0;
    end else begin
      if (fifo_wr & ~fifo_rd & ~ovf)      occ <= occ + 1'b1;
      else if (fifo_rd & ~fifo_wr & ~udf) occ <= occ - 1'b1;

      case ({launch, fifo_wr})
        2'b11:   resv <= resv + W'(MID_PIX - 1);
        2'b10:   resv <= resv + W'(MID_PIX);
        2'b01:   resv <= (resv == '0) ? '0 : resv - 1'b1;
        default: resv <= resv;
      endcase
    end
  end
endmodule

// File: rtl/gen_frame_sequencer.sv
// Admits host latent frames into layer 0 only when the bridge FIFO can absorb them; tracks batch completion.
module gen_frame_sequencer
  import gen_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IN_DIM     = GEN_IN_DIM,
  parameter int MID_DIM    = GEN_MID_DIM,
  parameter int OUT_DIM    = GEN_OUT_DIM,
  parameter int FIFO_DEPTH = GEN_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            num_frames,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  l0_valid,
  output logic [DATA_WIDTH-1:0] l0_data,
  input  logic                  fifo_wr,
  input  logic                  fifo_rd,
  input  logic                  out_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int IN_PIX  = IN_DIM * IN_DIM;
  localparam int MID_PIX = MID_DIM * MID_DIM;
  localparam int OUT_PIX = OUT_DIM * OUT_DIM;
  localparam int PIX_W   = $clog2(IN_PIX);

  gen_state_e             state, state_nxt;
  logic [FRM_W-1:0]       num_q;
  logic [FRM_W-1:0]       frm_issued;
  logic [PIX_W-1:0]       pix_cnt;
  logic [OUT_CNT_W-1:0]   out_cnt;
  logic [OUT_CNT_W-1:0]   out_target;
  logic                   accept, last_pix, frames_left, launch, drained;
  logic                   can_launch, ovf, udf;

  assign s_ready     = (state == ISSUE);
  assign busy        = (state != IDLE);
  assign accept      = s_valid & s_ready;
  assign last_pix    = accept & (pix_cnt == PIX_W'(IN_PIX - 1));
  assign frames_left = (frm_issued != num_q);
  assign launch      = (state == CHECK) & frames_left & can_launch;
  assign out_target  = OUT_CNT_W'(num_q) * OUT_CNT_W'(OUT_PIX);
  assign drained     = (out_cnt == out_target);

  gen_credit_tracker #(
    .MID_PIX    (MID_PIX),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .launch     (launch),
    .fifo_wr    (fifo_wr),
    .fifo_rd    (fifo_rd),
    .can_launch (can_launch),
    .ovf        (ovf),
    .udf        (udf)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_frames == '0) ? DONE : CHECK;
      CHECK:   if (!frames_left) state_nxt = DRAIN;
               else if (can_launch) state_nxt = ISSUE;
      ISSUE:   if (last_pix) state_nxt = CHECK;
      DRAIN:   if (drained) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      num_q      <= '0;
      frm_issued <= '0;
      pix_cnt    <= '0;
      out_cnt    <= '0;
      l0_valid   <= 1'b0;
      l0_data    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state    <= state_nxt;
      l0_valid <= accept;
      if (accept) l0_data <= s_data;
      // done is registered so it lands the cycle after DONE, once busy has dropped
      done     <= (state == DONE);
      err      <= err | ovf | udf | ((state == IDLE) & out_valid);

      if ((state == IDLE) && start) begin
        num_q      <= num_frames;
        frm_issued <= '0;
        out_cnt    <= '0;
      end else if ((state != IDLE) && out_valid) begin
        out_cnt <= out_cnt + 1'b1;
      end

      if (accept) pix_cnt <= last_pix ? '0 : pix_cnt + 1'b1;
      if (last_pix) frm_issued <= frm_issued + 1'b1;
    end
  end
endmodule

// File: tb/tb_gen_frame_sequencer.sv
// Bench for gen_frame_sequencer: cycle vector table, l0 scoreboard, and multi-cycle credit/batch sequences.
module tb_gen_frame_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_ready, l0_valid, fifo_wr, fifo_rd, out_valid;
  logic        busy, done, err;
  logic [7:0]  num_frames;
  logic [15:0] s_data, l0_data;

  int pass_cnt = 0, tot_cnt = 0;
  int acc_cnt = 0, l0_cnt = 0;
  bit acc_q = 1'b0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  gen_frame_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .num_frames(num_frames),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .l0_valid(l0_valid), .l0_data(l0_data),
    .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .out_valid(out_valid),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string name, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: push on accept, pop when l0_valid is seen one cycle later
  always @(posedge clk) begin
    acc_q = s_valid && s_ready && !rst;
    if (acc_q) begin
      exp_q.push_back(s_data);
      acc_cnt++;
    end
  end

  always @(negedge clk) begin
    if (acc_q || l0_valid === 1'b1) begin
      chk("l0_valid_latency", int'(l0_valid), int'(acc_q));
      if (l0_valid === 1'b1) begin
        l0_cnt++;
        if (exp_q.size() == 0) begin
          tot_cnt++;
          $display("FAIL l0_unexpected: l0_valid with empty scoreboard at %0t", $time);
        end else begin
          chk("l0_data", int'(l0_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; fifo_wr = 1'b0; fifo_rd = 1'b0; out_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_batch(input logic [7:0] nf);
    start = 1'b1; num_frames = nf;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input int n);
    int tgt = acc_cnt + n;
    int guard = 0;
    s_valid = 1'b1; s_data = 16'($urandom);
    while (acc_cnt < tgt && guard < 1000) begin
      tick();
      s_data = 16'($urandom);
      guard++;
    end
    s_valid = 1'b0;
    chk("stream_accepts", acc_cnt, tgt);
  endtask

  task automatic pulse_wr(input int n);
    fifo_wr = 1'b1; repeat (n) tick(); fifo_wr = 1'b0;
  endtask

  task automatic pulse_rd(input int n);
    fifo_rd = 1'b1; repeat (n) tick(); fifo_rd = 1'b0;
  endtask

  typedef struct {
    logic       rst, start;
    logic [7:0] nf;
    logic       s_valid, fifo_rd, out_valid;
    logic       e_ready, e_busy, e_done, e_err, e_l0v;
  } vec_t;
  vec_t tbl[14];

  initial begin
    int base, pend, seen;
    bit prev_ready;
    rst = 1'b1; start = 1'b0; num_frames = '0; s_valid = 1'b0; s_data = '0;
    fifo_wr = 1'b0; fifo_rd = 1'b0; out_valid = 1'b0;

    //          rst st nf sv rd ov | rdy bsy dn err l0v
    tbl[0]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};  // reset state
    tbl[1]  = '{0, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0};  // zero-frame batch
    tbl[2]  = '{0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 0};  // out_valid in IDLE
    tbl[5]  = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 0};  // read with occ 0
    tbl[8]  = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    tbl[10] = '{0, 1, 1, 0, 0, 0,   0, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0};  // launch -> ISSUE
    tbl[12] = '{0, 0, 0, 1, 0, 0,   1, 1, 0, 0, 1};
    tbl[13] = '{1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0};

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; num_frames = tbl[i].nf;
      s_valid = tbl[i].s_valid; s_data = 16'($urandom);
      fifo_rd = tbl[i].fifo_rd; out_valid = tbl[i].out_valid;
      tick();
      chk($sformatf("vec%0d_s_ready", i), int'(s_ready), int'(tbl[i].e_ready));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
      chk($sformatf("vec%0d_done", i), int'(done), int'(tbl[i].e_done));
      chk($sformatf("vec%0d_err", i), int'(err), int'(tbl[i].e_err));
      chk($sformatf("vec%0d_l0_valid", i), int'(l0_valid), int'(tbl[i].e_l0v));
    end
    do_reset();

    // single frame, full batch
    base = l0_cnt;
    start_batch(1);
    stream(64);
    tick(); tick();
    chk("t1_l0_count", l0_cnt - base, 64);
    chk("t1_ready_after_frame", int'(s_ready), 0);
    pulse_wr(169);
    pulse_rd(169);
    chk("t1_err", int'(err), 0);
    seen = 0;
    out_valid = 1'b1;
    for (int i = 0; i < 528; i++) begin
      tick();
      if (done) seen++;
    end
    chk("t1_no_early_done", seen, 0);
    tick();
    out_valid = 1'b0;
    chk("t1_done_a", int'(done), 0);
    tick();
    chk("t1_done_b", int'(done), 0);
    chk("t1_busy_b", int'(busy), 1);
    tick();
    chk("t1_done_pulse", int'(done), 1);
    chk("t1_busy_low", int'(busy), 0);
    tick();
    chk("t1_done_once", int'(done), 0);
    chk("t1_err_end", int'(err), 0);

    // credit backpressure: 6 frames fit, 7th needs 159 reads
    do_reset();
    base = acc_cnt; pend = 0; prev_ready = 1'b0;
    start_batch(8);
    s_valid = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      fifo_wr = (pend > 0);
      s_data = 16'($urandom);
      tick();
      if (fifo_wr) pend--;
      if (s_ready && !prev_ready) pend += 169;
      prev_ready = s_ready;
    end
    fifo_wr = 1'b0;
    chk("t2_six_frames", acc_cnt - base, 6 * 64);
    chk("t2_stalled_ready", int'(s_ready), 0);
    chk("t2_occ", int'(dut.u_credit.occ), 1014);
    chk("t2_err", int'(err), 0);
    pulse_rd(158);
    tick(); tick(); tick();
    chk("t2_still_stalled", int'(s_ready), 0);
    pulse_rd(1);
    for (int c = 0; c < 4 && !s_ready; c++) tick();
    chk("t2_seventh_launch", int'(s_ready), 1);
    s_valid = 1'b0;
    tick(); tick();

    // simultaneous write and read leave occ unchanged, drain reservation
    do_reset();
    start_batch(1);
    pulse_wr(100);
    fifo_wr = 1'b1; fifo_rd = 1'b1;
    repeat (50) tick();
    fifo_wr = 1'b0; fifo_rd = 1'b0;
    chk("t3_occ", int'(dut.u_credit.occ), 100);
    chk("t3_resv", int'(dut.u_credit.resv), 19);
    chk("t3_err", int'(err), 0);

    // reset mid-issue abandons the batch
    do_reset();
    start_batch(1);
    stream(30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_ready", int'(s_ready), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_pix_cnt", int'(dut.pix_cnt), 0);
    chk("t5_resv", int'(dut.u_credit.resv), 0);
    seen = 0;
    repeat (3) begin tick(); if (done) seen++; end
    chk("t5_no_done", seen, 0);
    base = l0_cnt;
    start_batch(1);
    stream(64);
    tick(); tick();
    chk("t5_full_frame", l0_cnt - base, 64);
    chk("t5_frm_issued", int'(dut.frm_issued), 1);
    chk("t5_ready_after", int'(s_ready), 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
